// File: rtl/sr_latch_write_ctrl.sv
// ============================================================================
// Module   : sr_latch_write_ctrl
// Brief    : Write sequencer for a bank of N gated SR latches. Turns one
//            accepted request into SETUP -> PULSE -> HOLD -> CHECK, never
//            presents S=R=1, never moves S/R while Enable is high, and checks
//            the latch readback against the written data.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_latch_write_ctrl #(
  parameter int N            = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_data,
  input  logic [N-1:0] req_mask,
  output logic         enable,
  output logic [N-1:0] s,
  output logic [N-1:0] r,
  input  logic [N-1:0] q_in,
  output logic         done,
  output logic         err,
  output logic [N-1:0] shadow
);

  localparam int C_MAX_CNT = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
  localparam int C_CW      = $clog2(C_MAX_CNT + 1);
  // Counters load "cycles remaining minus one" and the state exits at zero.
  localparam logic [C_CW-1:0] C_PULSE_LOAD = C_CW'(PULSE_CYCLES - 1);
  localparam logic [C_CW-1:0] C_HOLD_LOAD  = C_CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    data_q, data_d;
  logic [N-1:0]    mask_q, mask_d;
  logic            enable_q, enable_d;
  logic [N-1:0]    s_q, s_d;
  logic [N-1:0]    r_q, r_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [N-1:0]    shadow_q, shadow_d;
  logic            accept;

  // Ready only in IDLE and never while reset is asserted.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign enable = enable_q;
  assign s      = s_q;
  assign r      = r_q;
  assign done   = done_q;
  assign err    = err_q;
  assign shadow = shadow_q;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    mask_d   = mask_q;
    enable_d = 1'b0;
    s_d      = s_q;
    r_d      = r_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: begin
        s_d = '0;
        r_d = '0;
        if (accept) begin
          data_d = req_data;
          mask_d = req_mask;
          if (req_mask != '0) begin
            state_d = SETUP;
            // S and R are complementary only on masked channels, so S&R is never 1.
            s_d     = req_data & req_mask;
            r_d     = ~req_data & req_mask;
          end else begin
            // Nothing to write: report completion straight away, no error.
            state_d = CHECK;
            done_d  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d  = PULSE;
        cnt_d    = C_PULSE_LOAD;
        enable_d = 1'b1;
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = C_HOLD_LOAD;
        end else begin
          cnt_d    = cnt_q - C_CW'(1);
          enable_d = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          // Readback is sampled in the last HOLD cycle, after Enable has fallen.
          state_d  = CHECK;
          s_d      = '0;
          r_d      = '0;
          done_d   = 1'b1;
          err_d    = |(mask_q & (q_in ^ data_q));
          shadow_d = (shadow_q & ~mask_q) | (data_q & mask_q);
        end else begin
          cnt_d = cnt_q - C_CW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        r_d     = '0;
      end
    endcase
  end

  // FSM state, counter, request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      enable_q <= 1'b0;
      s_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      enable_q <= enable_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  // Set and Reset are never asserted together on any channel.
  a_no_sr_overlap : assert property (@(posedge clk) (s_q & r_q) == '0);

  // S/R move only across an edge where Enable is low on both sides (reset edges excepted).
  a_sr_stable : assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && ((s_q != $past(s_q)) || (r_q != $past(r_q))))
      |-> (!enable_q && !$past(enable_q)));

  // Enable is high exactly while in PULSE.
  a_enable_pulse : assert property (@(posedge clk) disable iff (rst)
    enable_q == (state_q == PULSE));

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_write_ctrl.sv
// ============================================================================
// Module   : tb_sr_latch_write_ctrl
// Brief    : Self-checking bench for sr_latch_write_ctrl with a behavioural
//            latch bank and a queue of expected write results.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_write_ctrl;

  localparam int N = 4;
  localparam int P = 2;
  localparam int H = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_data;
  logic [N-1:0] req_mask;
  logic         enable;
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic [N-1:0] q_in;
  logic         done;
  logic         err;
  logic [N-1:0] shadow;

  typedef struct {
    logic [N-1:0] s;
    logic [N-1:0] r;
    logic         err;
    logic [N-1:0] shadow;
    int           lat;
    int           en_cnt;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] sh_model = '0;
  logic [N-1:0] q_model  = '0;
  logic [N-1:0] stuck0   = '0;
  int           n_pass   = 0;
  int           n_total  = 0;

  always #5 clk = ~clk;

  // Behavioural gated SR latch bank; stuck0 forces selected Q bits low.
  always @(posedge clk) if (enable) q_model <= (q_model & ~r) | s;
  assign q_in = q_model & ~stuck0;

  sr_latch_write_ctrl #(.N(N), .PULSE_CYCLES(P), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask), .enable(enable), .s(s), .r(r),
    .q_in(q_in), .done(done), .err(err), .shadow(shadow)
  );

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_data = '1; req_mask = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if ({enable, s, r, done, err, req_ready} !== '0)
        $display("FAIL reset_outputs[%0d]: got en=%b s=%b r=%b done=%b err=%b rdy=%b required all 0",
                 i, enable, s, r, done, err, req_ready);
      else n_pass++;
      n_total++;
      if (shadow !== '0) $display("FAIL reset_shadow: got %b required 0000", shadow);
      else n_pass++;
    end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", req_ready);
    else n_pass++;
  endtask

  task automatic do_write(input string name, input logic [N-1:0] d, input logic [N-1:0] m);
    exp_t e;
    exp_t got;
    int   lim;
    bit   seen_done;
    int   en_cnt;
    int   en_first;
    e.s      = d & m;
    e.r      = ~d & m;
    e.err    = |(m & d & stuck0);
    e.shadow = (sh_model & ~m) | (d & m);
    e.lat    = (m != '0) ? (2 + P + H) : 1;
    e.en_cnt = (m != '0) ? P : 0;
    sb.push_back(e);
    sh_model = e.shadow;
    @(negedge clk);
    lim = 0;
    while (!req_ready && lim < 50) begin @(negedge clk); lim++; end
    n_total++;
    if (!req_ready) begin
      $display("FAIL %s_ready_timeout: got ready=0 required 1", name);
      void'(sb.pop_front());
      return;
    end else n_pass++;
    req_valid = 1'b1; req_data = d; req_mask = m;
    @(posedge clk);
    seen_done = 0; en_cnt = 0; en_first = -1;
    for (int j = 1; j <= 40 && !seen_done; j++) begin
      @(negedge clk);
      if (j == 1) begin req_valid = 1'b0; req_data = ~d; req_mask = '1; end
      if (j == 1 && m != '0) begin
        n_total++;
        if (s !== sb[0].s || r !== sb[0].r)
          $display("FAIL %s_setup_sr: got s=%b r=%b required s=%b r=%b", name, s, r, sb[0].s, sb[0].r);
        else n_pass++;
      end
      if (enable) begin
        en_cnt++;
        if (en_first < 0) en_first = j;
      end
      if (done) begin
        seen_done = 1;
        got = sb.pop_front();
        n_total++;
        if (j != got.lat) $display("FAIL %s_latency: got %0d required %0d", name, j, got.lat);
        else n_pass++;
        n_total++;
        if (err !== got.err) $display("FAIL %s_err: got %b required %b", name, err, got.err);
        else n_pass++;
        n_total++;
        if (shadow !== got.shadow) $display("FAIL %s_shadow: got %b required %b", name, shadow, got.shadow);
        else n_pass++;
        n_total++;
        if (s !== '0 || r !== '0 || enable !== 1'b0)
          $display("FAIL %s_check_idle_sr: got s=%b r=%b en=%b required 0", name, s, r, enable);
        else n_pass++;
        n_total++;
        if (en_cnt != got.en_cnt) $display("FAIL %s_enable_cycles: got %0d required %0d", name, en_cnt, got.en_cnt);
        else n_pass++;
        if (m != '0) begin
          n_total++;
          if (en_first != 2) $display("FAIL %s_enable_start: got %0d required 2", name, en_first);
          else n_pass++;
        end
      end
    end
    if (!seen_done) begin
      n_total++;
      $display("FAIL %s_done_timeout: got no done required done", name);
      void'(sb.pop_front());
    end
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL %s_done_width: got %b required 0", name, done);
    else n_pass++;
  endtask

  task automatic test_full_mask();    do_write("full",    4'b1010, 4'b1111); endtask
  task automatic test_partial_mask(); do_write("partial", 4'b0101, 4'b0011); endtask

  task automatic test_stuck_latch();
    stuck0 = 4'b0100;
    do_write("stuck", 4'b0100, 4'b0100);
    stuck0 = '0;
  endtask

  task automatic test_mask_zero();    do_write("mask0",   4'b1111, 4'b0000); endtask

  task automatic test_reset_in_pulse();
    @(negedge clk);
    req_valid = 1'b1; req_data = 4'b1111; req_mask = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (enable !== 1'b1) $display("FAIL rstpulse_in_pulse: got en=%b required 1", enable);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({enable, s, r, done, shadow} !== '0)
      $display("FAIL rstpulse_cleared: got en=%b s=%b r=%b done=%b shadow=%b required all 0",
               enable, s, r, done, shadow);
    else n_pass++;
    rst = 1'b0;
    sh_model = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (done !== 1'b0 || enable !== 1'b0)
        $display("FAIL rstpulse_no_done[%0d]: got done=%b en=%b required 0", i, done, enable);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    int   t_done[3];
    int   nd;
    e.s = 4'b0110; e.r = 4'b1001; e.err = 1'b0; e.shadow = 4'b0110;
    e.lat = 2 + P + H; e.en_cnt = P;
    for (int i = 0; i < 3; i++) sb.push_back(e);
    sh_model = e.shadow;
    @(negedge clk);
    req_valid = 1'b1; req_data = 4'b0110; req_mask = 4'b1111;
    nd = 0;
    for (int j = 0; j < 60 && nd < 3; j++) begin
      @(negedge clk);
      if (done) begin
        got = sb.pop_front();
        t_done[nd] = j;
        n_total++;
        if (err !== got.err || shadow !== got.shadow)
          $display("FAIL b2b_result[%0d]: got err=%b shadow=%b required err=%b shadow=%b",
                   nd, err, shadow, got.err, got.shadow);
        else n_pass++;
        nd++;
        if (nd == 3) req_valid = 1'b0;
      end
    end
    n_total++;
    if (nd != 3) begin
      $display("FAIL b2b_done_count: got %0d required 3", nd);
      while (sb.size() > 0) void'(sb.pop_front());
      req_valid = 1'b0;
    end else begin
      n_pass++;
      for (int i = 1; i < 3; i++) begin
        n_total++;
        if (t_done[i] - t_done[i-1] != 3 + P + H)
          $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, t_done[i] - t_done[i-1], 3 + P + H);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_data = '0; req_mask = '0;
    test_reset();
    test_full_mask();
    test_partial_mask();
    test_stuck_latch();
    test_mask_zero();
    test_reset_in_pulse();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
